antirrebote: RTL and testbench

ANTIRREBOTE -- requirements
Module: antirrebote

---
 rtl/antirrebote.sv | 159 +++++++++++++++
 tb/tb_antirrebote.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/antirrebote.sv
// Three-channel push-button debouncer producing one-clock load strobes.
// Each raw button goes through a 2-flop synchronizer and then its own
// four-state confirmation FSM; a press is accepted only after
// DEBOUNCE_CYCLES consecutive stable high samples. Releases never strobe.
// Simultaneous press events keep only the highest priority one (a > b > op).
// Optional build macro ANTIRREBOTE_ESTADO_EN adds the registered debounced
// level output estado[2:0] = {op, b, a}.
module antirrebote #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       boton_a_in,
    input  logic       boton_b_in,
    input  logic       boton_op_in,
    output logic       boton_a,
    output logic       boton_b,
    output logic       boton_op
`ifdef ANTIRREBOTE_ESTADO_EN
    ,
    output logic [2:0] estado
`endif
);

    typedef enum logic [1:0] {
        SUELTO       = 2'd0,
        CONF_PULSADO = 2'd1,
        PULSADO      = 2'd2,
        CONF_SUELTO  = 2'd3
    } estado_t;

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

    // Channel index 0 = a, 1 = b, 2 = op throughout.
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    estado_t          state_q [3];
    estado_t          state_d [3];
    logic [CNT_W-1:0] cnt_q   [3];
    logic [CNT_W-1:0] cnt_d   [3];
    logic [2:0]       press_ev;
    logic [2:0]       strobe_q, strobe_d;

    // Two-stage synchronizer inputs for the raw asynchronous buttons.
    always_comb begin
        sync1_d = {boton_op_in, boton_b_in, boton_a_in};
        sync2_d = sync1_q;
    end

    // Per-channel confirmation FSM and counter; counters stop at DEB_MAX because the FSM leaves the CONF state there.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            press_ev[i] = 1'b0;
            case (state_q[i])
                SUELTO: begin
                    if (sync2_q[i]) begin
                        state_d[i] = CONF_PULSADO;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                CONF_PULSADO: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = SUELTO;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] + CNT_W'(1) >= DEB_MAX) begin
                        state_d[i]  = PULSADO;
                        cnt_d[i]    = DEB_MAX;
                        press_ev[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                PULSADO: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = CONF_SUELTO;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                CONF_SUELTO: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PULSADO;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] + CNT_W'(1) >= DEB_MAX) begin
                        state_d[i] = SUELTO;
                        cnt_d[i]   = DEB_MAX;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = SUELTO;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Priority encode simultaneous press events; losers are dropped, not queued.
    always_comb begin
        strobe_d    = 3'b000;
        strobe_d[0] = press_ev[0];
        strobe_d[1] = press_ev[1] & ~press_ev[0];
        strobe_d[2] = press_ev[2] & ~(|press_ev[1:0]);
    end

    // State, counter, synchronizer and strobe registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            strobe_q <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= SUELTO;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            strobe_q <= strobe_d;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign boton_a  = strobe_q[0];
    assign boton_b  = strobe_q[1];
    assign boton_op = strobe_q[2];

`ifdef ANTIRREBOTE_ESTADO_EN
    logic [2:0] estado_q, estado_d;

    // Debounced level is high while pressed or while a release is still being confirmed.
    always_comb begin
        estado_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            estado_d[i] = (state_d[i] == PULSADO) || (state_d[i] == CONF_SUELTO);
        end
    end

    // Register the debounced levels so they line up with the strobe cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= 3'b000;
        end else begin
            estado_q <= estado_d;
        end
    end

    assign estado = estado_q;
`endif

endmodule

// File: tb/tb_antirrebote.sv
// Directed self-checking bench for antirrebote with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge; the edge that follows is
// edge 0 of the watch window, so a clean press strobes after window edge 5.
module tb_antirrebote;

    logic clk;
    logic reset;
    logic boton_a_in, boton_b_in, boton_op_in;
    logic boton_a, boton_b, boton_op;
`ifdef ANTIRREBOTE_ESTADO_EN
    logic [2:0] estado;
`endif

    int compared;
    int mismatched;

    int cnt_a, cnt_b, cnt_op;
    int first_a, first_b, first_op;
    int tot_a, tot_b, tot_op;

    antirrebote #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .boton_a_in (boton_a_in),
        .boton_b_in (boton_b_in),
        .boton_op_in(boton_op_in),
        .boton_a    (boton_a),
        .boton_b    (boton_b),
        .boton_op   (boton_op)
`ifdef ANTIRREBOTE_ESTADO_EN
        ,
        .estado     (estado)
`endif
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive the three raw buttons right after an edge.
    task automatic applyStimulus(input logic a, input logic b, input logic op);
        boton_a_in  = a;
        boton_b_in  = b;
        boton_op_in = op;
    endtask

    // Run n edges, sampling 1 unit after each; count strobes and note first edge index.
    task automatic watch(input int n);
        cnt_a = 0; cnt_b = 0; cnt_op = 0;
        first_a = -1; first_b = -1; first_op = -1;
        for (int e = 0; e < n; e++) begin
            @(posedge clk);
            #1;
            if (boton_a === 1'b1) begin
                cnt_a++;
                if (first_a < 0) first_a = e;
            end
            if (boton_b === 1'b1) begin
                cnt_b++;
                if (first_b < 0) first_b = e;
            end
            if (boton_op === 1'b1) begin
                cnt_op++;
                if (first_op < 0) first_op = e;
            end
        end
        tot_a  += cnt_a;
        tot_b  += cnt_b;
        tot_op += cnt_op;
    endtask

    task automatic clearTotals();
        tot_a = 0; tot_b = 0; tot_op = 0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        clearTotals();
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("reset_async_outs", {29'd0, boton_op, boton_b, boton_a}, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outs", {29'd0, boton_op, boton_b, boton_a}, 0);
`ifdef ANTIRREBOTE_ESTADO_EN
        checkOutput("reset_estado", int'(estado), 0);
`endif
        reset = 1'b0;
        watch(4);
        checkOutput("idle_no_strobe", tot_a + tot_b + tot_op, 0);

        // Clean press of A held 20 cycles.
        clearTotals();
        applyStimulus(1'b1, 1'b0, 1'b0);
        watch(20);
        checkOutput("clean_a_count", cnt_a, 1);
        checkOutput("clean_a_edge", first_a, 5);
        checkOutput("clean_a_others", cnt_b + cnt_op, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        watch(10);
        checkOutput("clean_a_release", cnt_a + cnt_b + cnt_op, 0);

        // Bouncing B: 1,0,1,1,0 then held high.
        clearTotals();
        applyStimulus(1'b0, 1'b1, 1'b0); watch(1);
        applyStimulus(1'b0, 1'b0, 1'b0); watch(1);
        applyStimulus(1'b0, 1'b1, 1'b0); watch(1);
        applyStimulus(1'b0, 1'b1, 1'b0); watch(1);
        applyStimulus(1'b0, 1'b0, 1'b0); watch(1);
        checkOutput("bounce_b_quiet", tot_a + tot_b + tot_op, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        watch(20);
        checkOutput("bounce_b_count", cnt_b, 1);
        checkOutput("bounce_b_edge", first_b, 5);
`ifdef ANTIRREBOTE_ESTADO_EN
        checkOutput("estado_b_held", int'(estado), 2);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0);
        watch(10);
        checkOutput("bounce_b_release", cnt_b, 0);
`ifdef ANTIRREBOTE_ESTADO_EN
        checkOutput("estado_b_released", int'(estado), 0);
`endif

        // Boundary: 3 stable samples are not enough, 4 are.
        clearTotals();
        applyStimulus(1'b0, 1'b1, 1'b0); watch(3);
        applyStimulus(1'b0, 1'b0, 1'b0); watch(10);
        checkOutput("short_b_3", tot_b, 0);
        clearTotals();
        applyStimulus(1'b0, 1'b1, 1'b0); watch(4);
        applyStimulus(1'b0, 1'b0, 1'b0); watch(10);
        checkOutput("exact_b_4", tot_b, 1);

        // Op: held 100, low 10, high 10, then a 2-cycle release glitch.
        clearTotals();
        applyStimulus(1'b0, 1'b0, 1'b1); watch(100);
        checkOutput("hold_op_first", cnt_op, 1);
        applyStimulus(1'b0, 1'b0, 1'b0); watch(10);
        applyStimulus(1'b0, 1'b0, 1'b1); watch(10);
        checkOutput("repress_op_edge", first_op, 5);
        checkOutput("hold_op_total", tot_op, 2);
        clearTotals();
        applyStimulus(1'b0, 1'b0, 1'b0); watch(2);
        applyStimulus(1'b0, 1'b0, 1'b1); watch(20);
        checkOutput("glitch_op", tot_op, 0);
        applyStimulus(1'b0, 1'b0, 1'b0); watch(10);

        // A and op rise on the same edge.
        clearTotals();
        applyStimulus(1'b1, 1'b0, 1'b1);
        watch(20);
        checkOutput("simul_a_count", cnt_a, 1);
        checkOutput("simul_a_edge", first_a, 5);
        checkOutput("simul_op_dropped", cnt_op, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        watch(10);
        checkOutput("simul_release", cnt_a + cnt_op, 0);

        // Reset in the middle of A confirmation, button kept held.
        clearTotals();
        applyStimulus(1'b1, 1'b0, 1'b0);
        watch(4);
        reset = 1'b1;
        #1;
        checkOutput("midreset_outs", {29'd0, boton_op, boton_b, boton_a}, 0);
        @(posedge clk);
        #1;
        checkOutput("midreset_outs_edge", {29'd0, boton_op, boton_b, boton_a}, 0);
        reset = 1'b0;
        watch(20);
        checkOutput("midreset_pre_strobes", tot_a - cnt_a, 0);
        checkOutput("midreset_a_count", cnt_a, 1);
        checkOutput("midreset_a_edge", first_a, 5);
        applyStimulus(1'b0, 1'b0, 1'b0);
        watch(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
